stream_moving_avg: RTL and testbench

Streaming signed moving-average filter with valid handshaking, a run-time selectable power-of-two window, and a circular sample store. It computes the average from the updated sum, so each output already includes the sample just accepted. It sits in the sample datapath between the ADC front-end and downstream decimation/detection logic. It generalises the fixed-window shift-register averager to configurable depth and width, gapped input streams, rounding, and a fill indicator.

---
 rtl/mavg_pkg.sv | 24 ++
 rtl/mavg_ring_buf.sv | 30 +++
 rtl/stream_moving_avg.sv | 99 +++++++++
 tb/tb_stream_moving_avg.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mavg_pkg.sv
// Shared helpers for the moving-average datapath and future decimators.
package mavg_pkg;

  // Accumulator width that holds a full window of samples without overflow.
  function automatic int acc_width(input int data_width, input int log2_depth);
    return data_width + log2_depth;
  endfunction

  // Saturate a requested window exponent at the largest supported one.
  function automatic int clamp_log2_win(input int k, input int max_k);
    return (k > max_k) ? max_k : k;
  endfunction

  // Arithmetic right shift by k with round-half-up.
  // The caller sign-extends into 32 bits, so adding the bias cannot wrap.
  function automatic logic signed [31:0] round_shift(input logic signed [31:0] x,
                                                     input int k);
    logic signed [31:0] bias;
    if (k <= 0) return x;
    bias = 32'sd1 <<< (k - 1);
    return (x + bias) >>> k;
  endfunction

endpackage

// File: rtl/mavg_ring_buf.sv
// DEPTH x DATA_WIDTH sample store: one synchronous write port and one
// combinational read port. Storage is not reset; the fill counter upstream
// ensures stale entries are never used.
module mavg_ring_buf #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 10,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [AW-1:0]                waddr,
  input  logic signed [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]                raddr,
  output logic signed [DATA_WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    // Each row captures wdata when it is the addressed write slot.
    always_ff @(posedge clk) begin
      if (we && (waddr == AW'(i))) mem[i] <= wdata;
    end
  end

  // Read is combinational from the flops, so a same-cycle write to the
  // read slot returns the pre-write value.
  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_moving_avg.sv
// Streaming signed moving average over a run-time power-of-two window.
// Each output reflects the sum including the sample accepted on that edge.
module stream_moving_avg
  import mavg_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int LOG2_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [$clog2(LOG2_DEPTH+1)-1:0]      cfg_log2_win,
  input  logic                                 clear,
  input  logic                                 in_valid,
  input  logic signed [DATA_WIDTH-1:0]         din,
  output logic                                 out_valid,
  output logic signed [DATA_WIDTH-1:0]         dout,
  output logic                                 win_full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int ACC_W = acc_width(DATA_WIDTH, LOG2_DEPTH);
  localparam int KW    = $clog2(LOG2_DEPTH + 1);
  localparam int PW    = LOG2_DEPTH;
  localparam int FW    = LOG2_DEPTH + 1;

  logic [KW-1:0]                k_act;
  logic [KW-1:0]                k_cfg;
  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                rd_ptr;
  logic [FW-1:0]                fill_cnt;
  logic [FW-1:0]                fill_next;
  logic [FW-1:0]                win_len;
  logic signed [ACC_W-1:0]      sum;
  logic signed [ACC_W-1:0]      sum_next;
  logic signed [DATA_WIDTH-1:0] rdata;
  logic signed [DATA_WIDTH-1:0] oldest;
  logic signed [DATA_WIDTH-1:0] dout_next;
  logic                         flush;
  logic                         full_now;
  logic [1:0]                   vld_pipe;

  // Reset and clear act identically; a sample alongside either is dropped.
  assign flush       = ~rst_n | clear;
  assign vld_pipe[0] = in_valid & ~flush;

  assign k_cfg    = KW'(clamp_log2_win(int'(cfg_log2_win), LOG2_DEPTH));
  assign win_len  = FW'(1) << k_act;
  assign full_now = (fill_cnt == win_len);

  // Oldest slot sits W entries behind the write pointer; at W=DEPTH that is
  // the write slot itself, read before it is overwritten.
  assign rd_ptr = wr_ptr - win_len[PW-1:0];

  mavg_ring_buf #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (PW)
  ) u_buf (
    .clk   (clk),
    .we    (vld_pipe[0]),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Update path: evict only once the window holds W real samples.
  always_comb begin
    oldest    = full_now ? rdata : '0;
    sum_next  = sum + ACC_W'(din) - ACC_W'(oldest);
    fill_next = full_now ? fill_cnt : fill_cnt + FW'(1);
    dout_next = DATA_WIDTH'(round_shift(32'(sum_next), int'(k_act)));
  end

  // Filter state, window latch and registered outputs.
  always_ff @(posedge clk) begin
    if (flush) begin
      k_act       <= k_cfg;
      sum         <= '0;
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      dout        <= '0;
      win_full    <= 1'b0;
      vld_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) begin
        sum      <= sum_next;
        wr_ptr   <= wr_ptr + PW'(1);
        fill_cnt <= fill_next;
        dout     <= dout_next;
        win_full <= (fill_next == win_len);
      end
    end
  end

  assign out_valid = vld_pipe[1];

endmodule

// File: tb/tb_stream_moving_avg.sv
// Directed bench for stream_moving_avg: a vector table plus a full-depth
// wrap-around sequence with a small arithmetic reference.
module tb_stream_moving_avg;

  localparam int DW = 10;
  localparam int L2 = 4;
  localparam int KW = $clog2(L2 + 1);

  logic                 clk;
  logic                 rst_n;
  logic [KW-1:0]        cfg_log2_win;
  logic                 clear;
  logic                 in_valid;
  logic signed [DW-1:0] din;
  logic                 out_valid;
  logic signed [DW-1:0] dout;
  logic                 win_full;

  int n_pass = 0;
  int n_total = 0;

  stream_moving_avg #(.DATA_WIDTH(DW), .LOG2_DEPTH(L2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_log2_win (cfg_log2_win),
    .clear        (clear),
    .in_valid     (in_valid),
    .din          (din),
    .out_valid    (out_valid),
    .dout         (dout),
    .win_full     (win_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  rst_n;
    logic  clr;
    int    cfg;
    logic  vld;
    int    din;
    logic  ov;
    int    dout;
    logic  full;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input string name, input logic r, input logic c,
                              input int cfg, input logic v, input int d,
                              input logic ov, input int q, input logic f);
    vec_t t;
    t.name = name; t.rst_n = r; t.clr = c; t.cfg = cfg; t.vld = v; t.din = d;
    t.ov = ov; t.dout = q; t.full = f;
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic c, input int cfg,
                       input logic v, input int d);
    @(negedge clk);
    rst_n        = r;
    clear        = c;
    cfg_log2_win = KW'(cfg);
    in_valid     = v;
    din          = DW'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic ov, input int q,
                            input logic f);
    check({name, ".out_valid"}, int'(out_valid), int'(ov));
    check({name, ".dout"},      int'(dout),      q);
    check({name, ".win_full"},  int'(win_full),  int'(f));
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; cfg_log2_win = '0; in_valid = 1'b0; din = '0;

    //                name        rst  clr cfg vld  din    ov  dout full
    vecs[0]  = mk("reset",       1'b0, 1'b0, 2, 1'b0,    0, 1'b0,   0, 1'b0);
    vecs[1]  = mk("w4_s4",       1'b1, 1'b0, 0, 1'b1,    4, 1'b1,   1, 1'b0);
    vecs[2]  = mk("w4_s8",       1'b1, 1'b0, 0, 1'b1,    8, 1'b1,   3, 1'b0);
    vecs[3]  = mk("w4_s12",      1'b1, 1'b0, 0, 1'b1,   12, 1'b1,   6, 1'b0);
    vecs[4]  = mk("w4_s16",      1'b1, 1'b0, 0, 1'b1,   16, 1'b1,  10, 1'b1);
    vecs[5]  = mk("w4_s20",      1'b1, 1'b0, 3, 1'b1,   20, 1'b1,  14, 1'b1);
    vecs[6]  = mk("w4_s24",      1'b1, 1'b0, 0, 1'b1,   24, 1'b1,  18, 1'b1);
    vecs[7]  = mk("clr_w2",      1'b1, 1'b1, 1, 1'b0,    0, 1'b0,   0, 1'b0);
    vecs[8]  = mk("w2_neg3",     1'b1, 1'b0, 0, 1'b1,   -3, 1'b1,  -1, 1'b0);
    vecs[9]  = mk("w2_neg4",     1'b1, 1'b0, 0, 1'b1,   -4, 1'b1,  -3, 1'b1);
    vecs[10] = mk("clr_gap",     1'b1, 1'b1, 2, 1'b0,    0, 1'b0,   0, 1'b0);
    vecs[11] = mk("gap_s8a",     1'b1, 1'b0, 0, 1'b1,    8, 1'b1,   2, 1'b0);
    vecs[12] = mk("gap_idle1",   1'b1, 1'b0, 0, 1'b0,  -77, 1'b0,   2, 1'b0);
    vecs[13] = mk("gap_idle2",   1'b1, 1'b0, 0, 1'b0,   50, 1'b0,   2, 1'b0);
    vecs[14] = mk("gap_s8b",     1'b1, 1'b0, 0, 1'b1,    8, 1'b1,   4, 1'b0);
    vecs[15] = mk("clr_drop",    1'b1, 1'b1, 0, 1'b1,  100, 1'b0,   0, 1'b0);
    vecs[16] = mk("w1_s37",      1'b1, 1'b0, 0, 1'b1,   37, 1'b1,  37, 1'b1);
    vecs[17] = mk("w1_s5",       1'b1, 1'b0, 0, 1'b1,    5, 1'b1,   5, 1'b1);
    vecs[18] = mk("rst_mid",     1'b0, 1'b1, 1, 1'b1,   99, 1'b0,   0, 1'b0);
    vecs[19] = mk("post_rst10",  1'b1, 1'b0, 0, 1'b1,   10, 1'b1,   5, 1'b0);
    vecs[20] = mk("post_rst6",   1'b1, 1'b0, 0, 1'b1,    6, 1'b1,   8, 1'b1);

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rst_n, vecs[i].clr, vecs[i].cfg, vecs[i].vld, vecs[i].din);
      check_outs(vecs[i].name, vecs[i].ov, vecs[i].dout, vecs[i].full);
    end

    // Full-depth window: cfg 7 clamps to 16 taps; pointer wraps on sample 17.
    drive(1'b1, 1'b1, 7, 1'b0, 0);
    check_outs("clr_w16", 1'b0, 0, 1'b0);
    for (int n = 1; n <= 16; n++) begin
      drive(1'b1, 1'b0, 0, 1'b1, 511);
      check_outs($sformatf("w16_fill%0d", n), 1'b1, (511 * n + 8) >>> 4, n == 16);
    end
    drive(1'b1, 1'b0, 0, 1'b1, -512);
    check_outs("w16_evict", 1'b1, 447, 1'b1);
    drive(1'b1, 1'b0, 0, 1'b0, 0);
    check_outs("w16_hold", 1'b0, 447, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
